// File: rtl/arb_pkg.sv
// ============================================================================
// Module : arb_pkg
// Brief  : Shared state encoding and default sizing for the round-robin arbiter
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int c_default_n_req   = 4;
   localparam int c_default_timeout = 15;
   localparam int c_hold_w          = 8;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin pick: first set req bit at/after ptr, with wrap
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] pick,
   output logic             valid
);

   always_comb begin
      logic [PTR_W-1:0] w_idx;
      pick  = '0;
      valid = 1'b0;
      w_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_idx = PTR_W'((int'(ptr) + i) % N_REQ);
         if (!valid && req[w_idx]) begin
            pick[w_idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/onehot_rr_arbiter.sv
// ============================================================================
// Module : onehot_rr_arbiter
// Brief  : Registered one-hot round-robin arbiter with done/drop/timeout release
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module onehot_rr_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ   = c_default_n_req,
   parameter int TIMEOUT = c_default_timeout
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic                     done,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy,
   output logic                     timeout
);

   localparam int c_id_w = $clog2(N_REQ);

   arb_state_t          r_state, w_state_next;
   logic [c_id_w-1:0]   r_ptr, w_ptr_next;
   logic [c_hold_w-1:0] r_hold, w_hold_next;
   logic [N_REQ-1:0]    r_grant, w_grant_next;
   logic [c_id_w-1:0]   r_grant_id, w_grant_id_next;
   logic                r_busy, r_timeout, w_timeout_next;

   logic [N_REQ-1:0]    w_pick;
   logic                w_pick_valid;
   logic [c_id_w-1:0]   w_pick_id;
   logic                w_owner_req, w_timer_hit, w_release;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (c_id_w)
   ) u_rr_pick (
      .req   (req),
      .ptr   (r_ptr),
      .pick  (w_pick),
      .valid (w_pick_valid)
   );

   always_comb begin
      w_pick_id = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_pick[i]) w_pick_id = c_id_w'(i);
      end
   end

   // The timer fires at the end of the TIMEOUT-th owned cycle.
   assign w_owner_req = |(req & r_grant);
   assign w_timer_hit = (r_hold == c_hold_w'(TIMEOUT - 1));
   assign w_release   = done || !w_owner_req || w_timer_hit;

   always_comb begin
      w_state_next    = r_state;
      w_ptr_next      = r_ptr;
      w_hold_next     = r_hold;
      w_grant_next    = r_grant;
      w_grant_id_next = r_grant_id;
      w_timeout_next  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_pick_valid) begin
               w_state_next    = GRANT;
               w_grant_next    = w_pick;
               w_grant_id_next = w_pick_id;
               w_hold_next     = '0;
            end
         end
         GRANT: begin
            if (w_release) begin
               w_state_next    = IDLE;
               w_grant_next    = '0;
               w_grant_id_next = '0;
               w_hold_next     = '0;
               w_ptr_next      = c_id_w'((int'(r_grant_id) + 1) % N_REQ);
               // A done or a request drop in the same cycle wins over the timer.
               w_timeout_next  = w_timer_hit && !done && w_owner_req;
            end else if (r_hold != '1) begin
               w_hold_next = r_hold + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_hold     <= '0;
         r_grant    <= '0;
         r_grant_id <= '0;
         r_busy     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_ptr      <= w_ptr_next;
         r_hold     <= w_hold_next;
         r_grant    <= w_grant_next;
         r_grant_id <= w_grant_id_next;
         r_busy     <= (w_state_next == GRANT);
         r_timeout  <= w_timeout_next;
      end
   end

   assign grant    = r_grant;
   assign grant_id = r_grant_id;
   assign busy     = r_busy;
   assign timeout  = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
// ============================================================================
// Module : tb_onehot_rr_arbiter
// Brief  : Directed scoreboard bench for onehot_rr_arbiter (N_REQ=4, TIMEOUT=15)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_onehot_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       busy;
   logic       timeout;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      string      tag;
      logic [3:0] g;
      logic [1:0] id;
      logic       b;
      logic       t;
   } exp_t;

   exp_t sb[$];

   onehot_rr_arbiter #(
      .N_REQ   (4),
      .TIMEOUT (15)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .done     (done),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy),
      .timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the outputs expected after the edge, then check them.
   task automatic step(input string tag, input logic [3:0] r, input logic d, input logic rs,
                       input logic [3:0] eg, input logic [1:0] eid, input logic eb, input logic et);
      exp_t e;
      req  = r;
      done = d;
      rst  = rs;
      sb.push_back('{tag, eg, eid, eb, et});
      if (!rs) chk({tag, "_req_known"}, {7'd0, !$isunknown(req)}, 8'd1);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.tag, "_grant"},    {4'd0, grant},    {4'd0, e.g});
      chk({e.tag, "_grant_id"}, {6'd0, grant_id}, {6'd0, e.id});
      chk({e.tag, "_busy"},     {7'd0, busy},     {7'd0, e.b});
      chk({e.tag, "_timeout"},  {7'd0, timeout},  {7'd0, e.t});
      chk({e.tag, "_onehot0"},  {7'd0, $onehot0(grant)}, 8'd1);
   endtask

   initial begin
      logic [3:0] g;
      rst  = 1'b1;
      req  = '0;
      done = 1'b0;
      @(posedge clk);
      #1;

      step("reset0", 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
      step("reset1", 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

      for (int i = 0; i < 5; i++)
         step("idle_noreq", 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Two requesters, ptr=0: owner 1, then owner 3 after release.
      step("rr_first",   4'b1010, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
      step("rr_done",    4'b1010, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
      step("rr_second",  4'b1010, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
      step("rr_drop",    4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

      // All requesting, done two cycles after each grant: full rotation plus wrap.
      for (int i = 0; i < 5; i++) begin
         g = 4'b0001 << (i % 4);
         step("rot_grant", 4'b1111, 1'b0, 1'b0, g, 2'(i % 4), 1'b1, 1'b0);
         step("rot_hold",  4'b1111, 1'b0, 1'b0, g, 2'(i % 4), 1'b1, 1'b0);
         step("rot_rel",   4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
      end
      step("rot_idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Held grant with no done: 15 owned cycles, then a forced release.
      for (int i = 0; i < 15; i++)
         step("to_hold", 4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
      step("to_fire",  4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
      step("to_pulse", 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

      // ptr=3 after the timeout; owner 2 drops its request after hold count 3.
      for (int i = 0; i < 4; i++)
         step("drop_hold", 4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
      step("drop_rel",  4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
      step("idle_done", 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
      step("ptr3_pick", 4'b1001, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);

      // Reset during ownership, then arbitration restarts from requester 0.
      step("rst_abort", 4'b1001, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
      step("post_rst",  4'b1001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
      step("final_rel", 4'b1001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
